delay_tap_calibrator: RTL and testbench

//  Synchronous calibration controller for a tapped matched-delay chain built from unit delay cells
//  (each unit = delay element ANDed with its enable). Searches for the largest tap count whose

---
 rtl/delay_tap_calibrator.sv | 190 +++++++++++++++++++
 tb/tb_delay_tap_calibrator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/delay_tap_calibrator.sv
// ---------------------------------------------------------------------------
// delay_tap_calibrator
//   Sizes a tapped matched-delay chain at bring-up. For each tap count, starting
//   at 0, it repeatedly flushes the chain (enable low), launches a test edge and
//   checks whether the edge reached the external capture flop within one clock.
//   The search stops at the first failing trial or at MAX_TAP. It then backs off
//   by MARGIN taps and holds the result.
//
// Ports
//   i_clk         clock
//   i_rst         synchronous reset, active-high
//   i_cal_start   start calibration (sampled only in IDLE or DONE)
//   i_cap_R       registered chain output from the capture flop (1 = edge arrived)
//   o_tap_sel     tap count driven to the chain mux
//   o_chain_en    enable for every unit cell (0 forces the chain low)
//   o_launch_R    test edge into the chain input
//   o_busy        calibration in progress
//   o_done        result valid (held in DONE)
//   o_err         search hit a boundary (tap 0 failed or MAX_TAP passed)
//   o_tap_locked  calibrated tap count
// ---------------------------------------------------------------------------
module delay_tap_calibrator #(
    parameter int TAP_W      = 5,
    parameter int MAX_TAP    = 31,
    parameter int SETTLE_CYC = 4,
    parameter int NTRIAL     = 4,
    parameter int MARGIN     = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cal_start,
    input  logic             i_cap_R,
    output logic [TAP_W-1:0] o_tap_sel,
    output logic             o_chain_en,
    output logic             o_launch_R,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [TAP_W-1:0] o_tap_locked
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int NW = (NTRIAL > 1) ? $clog2(NTRIAL) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [NW-1:0]    TRIAL_LAST  = NW'(NTRIAL - 1);
    localparam logic [TAP_W-1:0] TAP_MAX     = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] TAP_TOP_LCK = TAP_W'(MAX_TAP - MARGIN);
    localparam logic [TAP_W:0]   BACKOFF     = (TAP_W + 1)'(MARGIN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LAUNCH, S_CAPT, S_CHECK, S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SW-1:0]    r_settle;
    logic [NW-1:0]    r_trial;
    logic [TAP_W-1:0] r_tap;
    logic [TAP_W-1:0] r_locked;
    logic             r_cap;
    logic             r_chain_en;
    logic             r_launch;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_chain_en_nxt;
    logic             w_launch_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_start;
    logic             w_trial_last;
    logic             w_tap_max;
    logic [TAP_W-1:0] w_fail_lock;

    // Subtraction in TAP_W+1 bits: a borrow shows up in the top bit, which
    // means the result went negative and is clamped to 0.
    function automatic logic [TAP_W-1:0] sat_sub(input logic [TAP_W-1:0] a,
                                                  input logic [TAP_W:0]   b);
        logic [TAP_W:0] d;
        d = {1'b0, a} - b;
        return d[TAP_W] ? '0 : d[TAP_W-1:0];
    endfunction

    assign w_start      = i_cal_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_trial_last = (r_trial == TRIAL_LAST);
    assign w_tap_max    = (r_tap == TAP_MAX);
    assign w_fail_lock  = sat_sub(r_tap, BACKOFF);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_cal_start) w_state_nxt = S_CLEAR;
            S_CLEAR:  if (r_settle == SETTLE_LAST) w_state_nxt = S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_CAPT;
            S_CAPT:   w_state_nxt = S_CHECK;
            S_CHECK:  w_state_nxt = (r_cap && !(w_trial_last && w_tap_max)) ? S_CLEAR : S_DONE;
            S_DONE:   if (i_cal_start) w_state_nxt = S_CLEAR;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output is a register
    always_comb begin
        w_chain_en_nxt = 1'b0;
        w_launch_nxt   = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        case (w_state_nxt)
            S_CLEAR:  w_busy_nxt = 1'b1;
            S_LAUNCH, S_CAPT, S_CHECK: begin
                w_busy_nxt     = 1'b1;
                w_chain_en_nxt = 1'b1;
                w_launch_nxt   = 1'b1;
            end
            S_DONE: begin
                w_done_nxt     = 1'b1;
                w_chain_en_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // State register, counters and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_settle   <= '0;
            r_trial    <= '0;
            r_tap      <= '0;
            r_locked   <= '0;
            r_chain_en <= 1'b0;
            r_launch   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_chain_en <= w_chain_en_nxt;
            r_launch   <= w_launch_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            if (w_start) begin
                r_tap    <= '0;
                r_trial  <= '0;
                r_settle <= '0;
                r_err    <= 1'b0;
            end
            if (r_state == S_CLEAR)
                r_settle <= (r_settle == SETTLE_LAST) ? '0 : r_settle + 1'b1;
            if (r_state == S_CHECK) begin
                if (r_cap) begin
                    if (!w_trial_last) begin
                        r_trial <= r_trial + 1'b1;
                    end else if (!w_tap_max) begin
                        r_tap   <= r_tap + 1'b1;
                        r_trial <= '0;
                    end else begin
                        r_locked <= TAP_TOP_LCK;
                        r_tap    <= TAP_TOP_LCK;
                        r_err    <= 1'b1;
                    end
                end else if (r_tap == '0) begin
                    r_locked <= '0;
                    r_err    <= 1'b1;
                end else begin
                    r_locked <= w_fail_lock;
                    r_tap    <= w_fail_lock;
                    r_err    <= 1'b0;
                end
            end
        end
    end

    // The capture flop output only means something at the end of CAPT
    always_ff @(posedge i_clk) begin
        if (r_state == S_CAPT)
            r_cap <= i_cap_R;
    end

    assign o_tap_sel    = r_tap;
    assign o_chain_en   = r_chain_en;
    assign o_launch_R   = r_launch;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_tap_locked = r_locked;

endmodule

// File: tb/tb_delay_tap_calibrator.sv
module tb_delay_tap_calibrator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cs  = '0;
    logic [1:0] cap = '0;

    logic [4:0] tap_sel [2];
    logic [4:0] tap_lck [2];
    logic       chain_en[2];
    logic       launch  [2];
    logic       busy    [2];
    logic       done    [2];
    logic       err     [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    delay_tap_calibrator u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_cal_start(cs[0]), .i_cap_R(cap[0]),
        .o_tap_sel(tap_sel[0]), .o_chain_en(chain_en[0]), .o_launch_R(launch[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]), .o_tap_locked(tap_lck[0])
    );

    delay_tap_calibrator #(.SETTLE_CYC(1), .NTRIAL(1), .MARGIN(0)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_cal_start(cs[1]), .i_cap_R(cap[1]),
        .o_tap_sel(tap_sel[1]), .o_chain_en(chain_en[1]), .o_launch_R(launch[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]), .o_tap_locked(tap_lck[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Chain model: the edge arrives in time iff tap <= thr, except one
    // optionally injected failing trial (trial index ftrial at tap ftap).
    function automatic bit chain_pass(int tap, int tcnt, int thr, int ftap, int ftrial);
        return (tap <= thr) && !(tap == ftap && tcnt == ftrial);
    endfunction

    // Reference: walk the search at the level of taps and trials.
    task automatic ref_run(input int thr, input int ftap, input int ftrial,
                           input int ntrial, input int margin,
                           output int lock, output int e, output int trials);
        trials = 0;
        lock = 0;
        e = 0;
        for (int tap = 0; tap <= 31; tap++) begin
            for (int t = 0; t < ntrial; t++) begin
                trials++;
                if (!chain_pass(tap, t, thr, ftap, ftrial)) begin
                    if (tap == 0) begin lock = 0; e = 1; end
                    else begin lock = (tap - 1 - margin < 0) ? 0 : tap - 1 - margin; e = 0; end
                    return;
                end
            end
            if (tap == 31) begin lock = 31 - margin; e = 1; return; end
        end
    endtask

    // Starts one calibration on DUT sel and plays the chain until done.
    task automatic run_cal(input int sel, input int thr, input int ftap, input int ftrial,
                           input bit junk, input int abort_tap,
                           output int cyc, output int trials, output int lhi);
        int  ph, lasttap, tcnt, t;
        bit  prevl, fin;
        cyc = 0; trials = 0; lhi = 0;
        ph = 3; lasttap = -1; tcnt = 0; prevl = 0; fin = 0;
        @(negedge clk);
        cs[sel] = 1'b1;
        @(negedge clk);
        cs[sel] = 1'b0;
        chk("start_tap_sel", tap_sel[sel], 0);
        chk("start_busy", busy[sel], 1);
        chk("start_done", done[sel], 0);
        chk("start_err", err[sel], 0);
        for (int n = 0; n < 20000; n++) begin
            if (done[sel]) begin fin = 1; break; end
            t = int'(tap_sel[sel]);
            if (busy[sel]) cyc++;
            if (launch[sel]) lhi++;
            if (launch[sel] && !prevl) begin
                trials++;
                ph = 0;
                tcnt = (t == lasttap) ? tcnt + 1 : 0;
                lasttap = t;
            end else if (launch[sel]) begin
                ph++;
            end
            prevl = launch[sel];
            if (t == abort_tap && ph == 1 && launch[sel]) begin
                rst = 1'b1;
                return;
            end
            cap[sel] = (launch[sel] && ph == 1) ? chain_pass(t, tcnt, thr, ftap, ftrial)
                                                : 1'($urandom);
            if (junk) cs[sel] = 1'($urandom);
            @(negedge clk);
        end
        cs[sel] = 1'b0;
        chk("run_timeout", fin, 1);
    endtask

    task automatic check_run(input int sel, input int thr, input int ftap, input int ftrial,
                             input bit junk);
        int cyc, trials, lhi, elock, eerr, etr, ntr, mar, tl;
        ntr = sel ? 1 : 4;
        mar = sel ? 0 : 2;
        tl  = sel ? 4 : 7;
        ref_run(thr, ftap, ftrial, ntr, mar, elock, eerr, etr);
        run_cal(sel, thr, ftap, ftrial, junk, -1, cyc, trials, lhi);
        chk("done", done[sel], 1);
        chk("err", err[sel], eerr);
        chk("tap_locked", tap_lck[sel], elock);
        chk("tap_sel_done", tap_sel[sel], elock);
        chk("busy_done", busy[sel], 0);
        chk("chain_en_done", chain_en[sel], 1);
        chk("launch_done", launch[sel], 0);
        chk("trials", trials, etr);
        chk("cycles", cyc, etr * tl);
        chk("launch_cycles", lhi, 3 * etr);
    endtask

    initial begin
        int cyc, trials, lhi, thr, ftap, ftrial;
        repeat (3) @(negedge clk);
        chk("rst_tap_sel", tap_sel[0], 0);
        chk("rst_chain_en", chain_en[0], 0);
        chk("rst_launch", launch[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_err", err[0], 0);
        chk("rst_tap_locked", tap_lck[0], 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_chain_en", chain_en[0], 0);

        // Nominal: pass up to tap 12 -> locked 10 after 53 trials
        check_run(0, 12, -1, 0, 0);
        repeat (3) @(negedge clk);
        chk("hold_done", done[0], 1);
        chk("hold_locked", tap_lck[0], 10);
        // Restart from DONE, third trial of tap 5 fails
        check_run(0, 31, 5, 2, 0);
        // Boundaries: tap 0 fails; every tap passes; saturating back-off
        check_run(0, -1, -1, 0, 0);
        check_run(0, 31, -1, 0, 0);
        check_run(0, 1, -1, 0, 0);

        // Reset during CAPT at tap 7
        run_cal(0, 31, -1, 0, 0, 7, cyc, trials, lhi);
        chk("abort_trials", trials, 29);
        @(negedge clk);
        chk("abort_tap_sel", tap_sel[0], 0);
        chk("abort_chain_en", chain_en[0], 0);
        chk("abort_launch", launch[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_done", done[0], 0);
        chk("abort_err", err[0], 0);
        chk("abort_tap_locked", tap_lck[0], 0);
        rst = 1'b0;

        // Random chains with stray cal_start/cap_R while busy
        for (int i = 0; i < 6; i++) begin
            thr    = int'($urandom_range(0, 32)) - 1;
            ftap   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : -1;
            ftrial = int'($urandom_range(0, 3));
            check_run(0, thr, ftap, ftrial, 1);
        end

        // Short-trial configuration
        check_run(1, 3, -1, 0, 0);
        check_run(1, int'($urandom_range(0, 31)), -1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
